// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared definitions for the register_bank slice: FSM state
//            encoding, special register addresses and the write-mask merge
//            helper used by both the memory write path and read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Sweeper FSM encoding
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    // Special addresses
    localparam int unsigned ADDR_CTRL   = 0;
    localparam int unsigned ADDR_STATUS = 1;

    // Bitwise masked merge. Kept at single-bit granularity so it is
    // independent of DATA_WIDTH; callers expand the per-lane mask to a
    // per-bit mask and apply this across the word.
    function automatic logic merge(input logic old_bit,
                                   input logic new_bit,
                                   input logic mask_bit);
        return mask_bit ? new_bit : old_bit;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_init_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : regfile_init_sweeper
// Purpose  : Owns the INIT/IDLE FSM and the sweep counter. While in INIT it
//            emits one zero-write per cycle across the whole address space,
//            then drops into IDLE and raises o_ready.
// Ports    : clock, reset        - clock / async active-high reset
//            i_clear             - request a new sweep (honoured in IDLE only)
//            o_ready             - high in IDLE, host accesses accepted
//            o_sweep_we          - sweep write strobe into the memory mux
//            o_sweep_addr        - address being zeroed this cycle
// Revision : 1.0 - initial release
// ============================================================================
module regfile_init_sweeper
    import regfile_pkg::*;
#(
    parameter int ADDR_DEPTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_clear,
    output logic                  o_ready,
    output logic                  o_sweep_we,
    output logic [ADDR_DEPTH-1:0] o_sweep_addr
);

    localparam logic [ADDR_DEPTH-1:0] c_LAST_ADDR = '1;
    localparam logic [ADDR_DEPTH-1:0] c_ONE       = ADDR_DEPTH'(1);

    logic [0:0]            r_state;
    logic [ADDR_DEPTH-1:0] r_count;

    // The terminal count is detected explicitly, so the counter is parked at
    // zero on exit rather than relying on natural wrap-around.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_count == c_LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end
                ST_IDLE: begin
                    if (i_clear) begin
                        r_state <= ST_INIT;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign o_ready      = (r_state == ST_IDLE);
    assign o_sweep_we   = (r_state == ST_INIT);
    assign o_sweep_addr = r_count;

endmodule : regfile_init_sweeper
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module   : register_bank
// Purpose  : Parametrised register file between the host/config sequencer
//            and the classifier core. Independent write and read ports,
//            per-lane write masks, write-first forwarding, a control word at
//            address 0 mirrored on control_reg, a read-only status word at
//            address 1, and a hardware zeroing sweep after reset / clear.
// Ports    : clock, reset          - clock / async active-high reset
//            clear                 - start a new init sweep (IDLE only)
//            wr_en/wr_addr/wr_data/wr_mask - masked write port
//            rd_en/rd_addr         - read request
//            status_in             - live status returned on reads of addr 1
//            rd_data/rd_valid      - registered read data and its valid pulse
//            ready                 - high when accesses are accepted
//            control_reg           - low CTRL_WIDTH bits of word 0
// Revision : 1.0 - initial release
// ============================================================================
module register_bank
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int ADDR_DEPTH   = 12,
    parameter int LANE_WIDTH   = 8,
    parameter int CTRL_WIDTH   = 8,
    parameter int STATUS_WIDTH = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             wr_en,
    input  logic [ADDR_DEPTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_mask,
    input  logic                             rd_en,
    input  logic [ADDR_DEPTH-1:0]            rd_addr,
    input  logic [STATUS_WIDTH-1:0]          status_in,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             ready,
    output logic [CTRL_WIDTH-1:0]            control_reg
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_DEPTH;

    localparam logic [ADDR_DEPTH-1:0] c_ADDR_CTRL   = ADDR_DEPTH'(ADDR_CTRL);
    localparam logic [ADDR_DEPTH-1:0] c_ADDR_STATUS = ADDR_DEPTH'(ADDR_STATUS);

    // ------------------------------------------------------------------
    // Init sweeper / FSM
    // ------------------------------------------------------------------
    logic                  w_ready;
    logic                  w_sweep_we;
    logic [ADDR_DEPTH-1:0] w_sweep_addr;

    regfile_init_sweeper #(
        .ADDR_DEPTH (ADDR_DEPTH)
    ) u_sweeper (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (clear),
        .o_ready      (w_ready),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr)
    );

    assign ready = w_ready;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Lane mask expansion and masked merge of the write word
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_bitmask;

    for (genvar g = 0; g < LANES; g++) begin : g_lane_mask
        assign w_bitmask[g*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wr_mask[g]}};
    end

    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_wr_merged;

    assign w_wr_old = r_mem[wr_addr];

    always_comb begin
        w_wr_merged = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            w_wr_merged[b] = merge(w_wr_old[b], wr_data[b], w_bitmask[b]);
        end
    end

    // Host accesses only take effect in IDLE; the status address is
    // read-only so writes aimed at it are dropped here.
    logic w_host_we;
    logic w_host_re;

    assign w_host_we = w_ready & wr_en & (wr_addr != c_ADDR_STATUS);
    assign w_host_re = w_ready & rd_en;

    // ------------------------------------------------------------------
    // Memory write mux: sweep zeroing vs host masked write. The two are
    // mutually exclusive since host writes require IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_sweep_we) begin
            r_mem[w_sweep_addr] <= '0;
        end else if (w_host_we) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

    // ------------------------------------------------------------------
    // Read path with write-first forwarding
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_status_ext;
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_rd_word;

    always_comb begin
        w_status_ext                 = '0;
        w_status_ext[STATUS_WIDTH-1:0] = status_in;
    end

    // w_host_we already excludes the status address, so a hit here never
    // shadows the status word.
    assign w_fwd_hit = w_host_we & (wr_addr == rd_addr);

    always_comb begin
        if (rd_addr == c_ADDR_STATUS) begin
            w_rd_word = w_status_ext;
        end else if (w_fwd_hit) begin
            w_rd_word = w_wr_merged;
        end else begin
            w_rd_word = r_mem[rd_addr];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= w_host_re;
            if (w_host_re) begin
                rd_data <= w_rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control register mirror of word 0
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            control_reg <= '0;
        end else if (w_sweep_we && (w_sweep_addr == c_ADDR_CTRL)) begin
            control_reg <= '0;
        end else if (w_host_we && (wr_addr == c_ADDR_CTRL)) begin
            control_reg <= w_wr_merged[CTRL_WIDTH-1:0];
        end
    end

endmodule : register_bank
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_bank
// Purpose  : Self-checking bench for register_bank (ADDR_DEPTH=4, 24-bit
//            words, 8-bit lanes). Directed scenarios plus a randomized run
//            compared against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_bank;

    localparam int DW    = 24;
    localparam int AW    = 4;
    localparam int LW    = 8;
    localparam int CW    = 8;
    localparam int SW    = 8;
    localparam int LANES = DW / LW;
    localparam int DEPTH = 2 ** AW;

    logic             clock;
    logic             reset;
    logic             clear;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [LANES-1:0] wr_mask;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [SW-1:0]    status_in;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             ready;
    logic [CW-1:0]    control_reg;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] exp_rd;
    logic          exp_valid;
    logic [CW-1:0] exp_ctrl;

    register_bank #(
        .DATA_WIDTH   (DW),
        .ADDR_DEPTH   (AW),
        .LANE_WIDTH   (LW),
        .CTRL_WIDTH   (CW),
        .STATUS_WIDTH (SW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_mask     (wr_mask),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .status_in   (status_in),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .ready       (ready),
        .control_reg (control_reg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        exp_ctrl = '0;
    endtask

    // One IDLE-state cycle: drives the ports, advances the model by the
    // rules (write lanes first, then read sees the updated word), clocks.
    task automatic cycle(input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [LANES-1:0] wm,
                         input logic re, input logic [AW-1:0] ra,
                         input logic clr);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_en = re; rd_addr = ra; clear = clr;
        if (we && wa != 1) begin
            for (int i = 0; i < LANES; i++)
                if (wm[i]) m_mem[wa][i*LW +: LW] = wd[i*LW +: LW];
        end
        if (re) exp_rd = (ra == 1) ? {{(DW-SW){1'b0}}, status_in} : m_mem[ra];
        exp_valid = re;
        exp_ctrl  = m_mem[0][CW-1:0];
        tick();
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        #2;
        total_cnt++;
        if (rd_data !== '0 || rd_valid !== 1'b0 || ready !== 1'b0 || control_reg !== '0)
            $display("FAIL reset_values: rd_data=%h rd_valid=%b ready=%b ctrl=%h, want 0/0/0/0",
                     rd_data, rd_valid, ready, control_reg);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        total_cnt++;
        if (n !== 16) $display("FAIL reset_sweep_len: ready after %0d edges, want 16", n);
        else pass_cnt++;
        model_clear();
        exp_rd = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (a == 1) continue;
            cycle(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== 24'h000000)
                $display("FAIL init_read[%0d]: rd_data=%h rd_valid=%b, want 000000/1", a, rd_data, rd_valid);
            else pass_cnt++;
        end
        cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
        total_cnt++;
        if (rd_valid !== 1'b0 || rd_data !== 24'h000000)
            $display("FAIL idle_hold: rd_data=%h rd_valid=%b, want 000000/0", rd_data, rd_valid);
        else pass_cnt++;
    endtask

    task automatic test_masked_forward();
        cycle(1'b1, 4'd5, 24'hAABBCC, 3'b111, 1'b0, '0, 1'b0);
        cycle(1'b1, 4'd5, 24'h112233, 3'b010, 1'b1, 4'd5, 1'b0);
        total_cnt++;
        if (rd_data !== 24'hAA22CC || rd_valid !== 1'b1)
            $display("FAIL forward_read: rd_data=%h rd_valid=%b, want AA22CC/1", rd_data, rd_valid);
        else pass_cnt++;
        cycle(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
        total_cnt++;
        if (rd_data !== 24'hAA22CC)
            $display("FAIL next_read: rd_data=%h, want AA22CC", rd_data);
        else pass_cnt++;
    endtask

    task automatic test_control();
        int n;
        cycle(1'b1, 4'd0, 24'h0000A5, 3'b001, 1'b0, '0, 1'b0);
        total_cnt++;
        if (control_reg !== 8'hA5)
            $display("FAIL ctrl_write: control_reg=%h, want A5", control_reg);
        else pass_cnt++;
        cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL clear_ready: ready=%b, want 0", ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (control_reg !== 8'h00)
            $display("FAIL ctrl_sweep: control_reg=%h, want 00", control_reg);
        else pass_cnt++;
        n = 1;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        total_cnt++;
        if (n !== 16) $display("FAIL clear_sweep_len: ready after %0d edges, want 16", n);
        else pass_cnt++;
        model_clear();
        cycle(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
        total_cnt++;
        if (rd_data !== 24'h000000)
            $display("FAIL clear_zeroed: rd_data=%h, want 000000", rd_data);
        else pass_cnt++;
    endtask

    task automatic test_status();
        int bad;
        status_in = 8'h3C;
        cycle(1'b1, 4'd1, 24'hFFFFFF, 3'b111, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b1, 4'd1, 1'b0);
        total_cnt++;
        if (rd_data !== 24'h00003C || rd_valid !== 1'b1)
            $display("FAIL status_read: rd_data=%h rd_valid=%b, want 00003C/1", rd_data, rd_valid);
        else pass_cnt++;
        // Start a sweep and hold read/write requests during it
        cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        bad = 0;
        rd_en = 1'b1; rd_addr = 4'd5;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rd_valid !== 1'b0) bad++;
        end
        rd_en = 1'b0;
        total_cnt++;
        if (bad != 0) $display("FAIL rd_in_sweep: rd_valid high %0d times, want 0", bad);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ready !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL sweep_end: ready=%b rd_valid=%b, want 1/0", ready, rd_valid);
        else pass_cnt++;
        model_clear();
    endtask

    task automatic test_reset_mid();
        int n;
        // Mid-access reset
        cycle(1'b1, 4'd0, 24'h00005A, 3'b001, 1'b0, '0, 1'b0);
        cycle(1'b1, 4'd7, 24'h123456, 3'b111, 1'b1, 4'd7, 1'b0);
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 24'h123456 || control_reg !== 8'h5A)
            $display("FAIL pre_reset: rd_data=%h rd_valid=%b ctrl=%h, want 123456/1/5A",
                     rd_data, rd_valid, control_reg);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (rd_data !== '0 || rd_valid !== 1'b0 || control_reg !== '0 || ready !== 1'b0)
            $display("FAIL async_reset_access: rd_data=%h rd_valid=%b ctrl=%h ready=%b, want 0",
                     rd_data, rd_valid, control_reg, ready);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        model_clear();
        // Load nonzero read data, then reset at sweep count 7
        cycle(1'b1, 4'd9, 24'hC0FFEE, 3'b111, 1'b1, 4'd9, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        total_cnt++;
        if (rd_data !== 24'hC0FFEE || ready !== 1'b0)
            $display("FAIL sweep_hold: rd_data=%h ready=%b, want C0FFEE/0", rd_data, ready);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (rd_data !== '0 || rd_valid !== 1'b0 || control_reg !== '0)
            $display("FAIL async_reset_sweep: rd_data=%h rd_valid=%b ctrl=%h, want 0",
                     rd_data, rd_valid, control_reg);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 24'hFFFFFF; wr_mask = 3'b111;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        wr_en = 1'b0;
        total_cnt++;
        if (n !== 16) $display("FAIL mid_reset_sweep_len: ready after %0d edges, want 16", n);
        else pass_cnt++;
        model_clear();
        cycle(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
        total_cnt++;
        if (rd_data !== 24'h000000 || rd_valid !== 1'b1)
            $display("FAIL sweep_write_dropped: rd_data=%h rd_valid=%b, want 000000/1", rd_data, rd_valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int bad;
        logic [AW-1:0] wa, ra;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            status_in = SW'($urandom);
            ra = AW'($urandom_range(0, DEPTH-1));
            wa = ($urandom_range(0, 1) == 1) ? ra : AW'($urandom_range(0, DEPTH-1));
            if ($urandom_range(0, 7) == 0) wa = 4'd0;
            cycle(1'($urandom), wa, DW'($urandom), LANES'($urandom),
                  1'($urandom), ra, 1'b0);
            total_cnt++;
            if (rd_data !== exp_rd || rd_valid !== exp_valid || control_reg !== exp_ctrl) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: rd_data=%h rd_valid=%b ctrl=%h, want %h/%b/%h",
                             i, rd_data, rd_valid, control_reg, exp_rd, exp_valid, exp_ctrl);
            end else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_mask = '0; rd_en = 1'b0; rd_addr = '0; status_in = '0;
        exp_rd = '0; exp_valid = 1'b0; exp_ctrl = '0;
        test_reset();
        test_masked_forward();
        test_control();
        test_status();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule : tb_register_bank
`default_nettype wire

// File: doc/register_bank.md
# register_bank

Parametrised successor to the 24-bit register file for the cat recogniser datapath.
- Memory: 2**ADDR_DEPTH words with independent write and read ports, per-lane write masks and write-first read-during-write forwarding.
- Special addresses: a control register (address 0) exposed as a flop output and a read-only status word (address 1).
- Initialisation: a hardware init sweep zeroes every word after reset or on request.
- Placement: between the host/config sequencer and the classifier core.

## Interface
Parameters:
- DATA_WIDTH, 24, word width; must be a multiple of LANE_WIDTH
- ADDR_DEPTH, 12, address bits; depth = 2**ADDR_DEPTH, minimum 2
- LANE_WIDTH, 8, bits per write-mask lane; LANES = DATA_WIDTH/LANE_WIDTH
- CTRL_WIDTH, 8, low bits of word 0 driven on control_reg (at most DATA_WIDTH)
- STATUS_WIDTH, 8, width of status_in (at most DATA_WIDTH)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  one-cycle request to start an init sweep
- wr_en  in  1  write request
- wr_addr  in  ADDR_DEPTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  LANES  per-lane write enable; bit i covers bits [i*LANE_WIDTH +: LANE_WIDTH]
- rd_en  in  1  read request
- rd_addr  in  ADDR_DEPTH  read address
- status_in  in  STATUS_WIDTH  live status, returned zero-extended on reads of address 1
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  one-cycle pulse, rd_data valid
- ready  out  1  high when accesses are accepted (IDLE)
- control_reg  out  CTRL_WIDTH  registered copy of word 0 bits [CTRL_WIDTH-1:0]

## Operation
- FSM states: INIT, IDLE.
- Reset puts the FSM in INIT with sweep counter at 0.
- INIT:
  - Each cycle writes 0 to mem[counter] and increments the counter.
  - After writing the last address (2**ADDR_DEPTH-1) the FSM goes to IDLE.
  - ready=0. wr_en, rd_en and clear are ignored, not queued.
- IDLE: ready=1. clear=1 moves the FSM to INIT with counter 0 on the next edge. Reads and writes in that same cycle are still performed.
- Write in IDLE: for each lane with wr_mask[i]=1, that lane of mem[wr_addr] takes wr_data. Unmasked lanes hold their value.
- Writes to address 1 are discarded. Status is read-only.
- Read in IDLE: rd_data takes mem[rd_addr] and rd_valid=1 on the next edge.
  - rd_addr=1 returns {zeros, status_in} sampled at the request edge.
- Simultaneous read and write to the same address (not 1): write-first. rd_data returns the old word with the masked lanes replaced by wr_data.
- No read in a cycle: rd_data holds its last value and rd_valid=0. The output is never high-impedance.
- control_reg follows word 0 bits [CTRL_WIDTH-1:0]:
  - updated on the edge that writes address 0, using masked-merge semantics;
  - cleared on the INIT write of address 0.

## Timing
- Reset values: rd_data=0, rd_valid=0, ready=0, control_reg=0. Memory contents are not reset; the sweep clears them.
- Read latency 1 cycle; write visible to any read issued the following cycle or later, and forwarded in the same cycle.
- Sweep:
  - Lasts exactly 2**ADDR_DEPTH cycles.
  - ready rises on the edge after the last sweep write. With ADDR_DEPTH=4, ready rises 16 edges after reset deassertion.
- clear sampled in IDLE: ready falls on the next edge. The sweep restarts from 0 even if an earlier sweep had completed.
- clear while in INIT: ignored, the sweep continues.
- Reset asserted mid-sweep or mid-access: all outputs go to reset values immediately and the sweep restarts from 0 after release.
- Counter wrap: the counter never wraps. The transition to IDLE is taken on the terminal count.

## Structure
- Shared package regfile_pkg:
  - state encoding (INIT, IDLE);
  - ADDR_CTRL=0 and ADDR_STATUS=1 constants;
  - lane-merge function merge(old, new, mask).
- Sub-module regfile_init_sweeper: owns the FSM, sweep counter, ready, and the sweep write address/enable into the memory mux.
- Top level holds the memory array, the write mux (sweep vs host), the read/forward path and the control_reg flop.

## Test plan
Bench parameters: ADDR_DEPTH=4, DATA_WIDTH=24, LANE_WIDTH=8, CTRL_WIDTH=8, STATUS_WIDTH=8.
1. Reset, then 16 idle cycles:
   - ready=0 for 16 cycles after release, then 1.
   - Reads of addresses 0, 2..15 return 0x000000 with rd_valid one cycle later.
2. Masked write and forwarding:
   - Write 0xAABBCC, mask 111 to address 5; next cycle write 0x112233, mask 010 to address 5 with a read of address 5 in the same cycle. The read returns 0xAA22CC.
   - Next-cycle read of address 5 also returns 0xAA22CC.
3. Control register:
   - Write 0x0000A5, mask 001 to address 0: control_reg=0xA5 one edge later.
   - Then pulse clear: control_reg=0x00 during the sweep; ready returns after 16 cycles.
4. Status port:
   - With status_in=0x3C, write 0xFFFFFF to address 1, then read address 1: rd_data=0x00003C.
   - rd_en while ready=0: rd_valid stays 0.
5. Reset mid-operation:
   - Assert reset at sweep count 7: rd_data, rd_valid, control_reg go to 0 immediately.
   - After release, ready rises exactly 16 cycles later.
   - A write attempted during the sweep to address 3 is absent: address 3 reads 0.
